// File: rtl/leitor_notas.sv
// rtl/leitor_notas.sv - note sequencer: walks a song in note memory, holding each note for its tick duration
module leitor_notas #(
    parameter int IDX_W  = 6,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                select,
    input  logic                      start,
    input  logic                      tick,
    input  logic                      pause,
    output logic [IDX_W+1:0]          mem_addr,
    input  logic [NOTE_W+DUR_W-1:0]   mem_data,
    output logic [NOTE_W-1:0]         nota,
    output logic                      tocando,
    output logic                      fim
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        BUSCA   = 3'd1,
        CARREGA = 3'd2,
        TOCA    = 3'd3,
        FIM     = 3'd4
    } estado_t;

    localparam logic [IDX_W-1:0] IDX_LAST = '1;
    localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
    localparam logic [DUR_W-1:0] DUR_ZERO = '0;

    estado_t           estado;
    logic [1:0]        song_reg;
    logic [IDX_W-1:0]  idx;
    logic [DUR_W-1:0]  dur_cnt;
    logic [NOTE_W-1:0] note_f;
    logic [DUR_W-1:0]  dur_f;

    assign mem_addr = {song_reg, idx};
    assign note_f   = mem_data[NOTE_W+DUR_W-1:DUR_W];
    assign dur_f    = mem_data[DUR_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado   <= OCIOSO;
            song_reg <= '0;
            idx      <= '0;
            dur_cnt  <= '0;
            nota     <= '0;
            tocando  <= 1'b0;
            fim      <= 1'b0;
        end else if (start) begin
            // Restart wins over every in-flight transition, including a pending tick or end pulse.
            estado   <= BUSCA;
            song_reg <= select;
            idx      <= '0;
            dur_cnt  <= '0;
            nota     <= '0;
            tocando  <= 1'b0;
            fim      <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    tocando <= 1'b0;
                    fim     <= 1'b0;
                end
                BUSCA: begin
                    estado <= CARREGA;
                end
                CARREGA: begin
                    if (dur_f == DUR_ZERO) begin
                        estado <= FIM;
                        fim    <= 1'b1;
                    end else begin
                        nota    <= note_f;
                        dur_cnt <= dur_f;
                        tocando <= 1'b1;
                        estado  <= TOCA;
                    end
                end
                TOCA: begin
                    if (tick && !pause) begin
                        dur_cnt <= dur_cnt - DUR_ONE;
                        if (dur_cnt == DUR_ONE) begin
                            tocando <= 1'b0;
                            // The last word of the song slot ends playback instead of wrapping to word 0.
                            if (idx == IDX_LAST) begin
                                estado <= FIM;
                                fim    <= 1'b1;
                            end else begin
                                idx    <= idx + 1'b1;
                                estado <= BUSCA;
                            end
                        end
                    end
                end
                FIM: begin
                    fim     <= 1'b0;
                    nota    <= '0;
                    tocando <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: begin
                    estado  <= OCIOSO;
                    tocando <= 1'b0;
                    fim     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leitor_notas.sv
// tb/tb_leitor_notas.sv - scoreboard bench for leitor_notas with memory and song-list reference model
module tb_leitor_notas;

    logic       clk;
    logic       reset;
    logic [1:0] select;
    logic       start;
    logic       tick;
    logic       pause;
    logic [7:0] mem_addr;
    logic [9:0] mem_data;
    logic [5:0] nota;
    logic       tocando;
    logic       fim;

    logic [9:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         is_end;
        logic [5:0] note;
        int         ticks;
    } ev_t;

    ev_t exp_q[$];

    leitor_notas dut (
        .clk      (clk),
        .reset    (reset),
        .select   (select),
        .start    (start),
        .tick     (tick),
        .pause    (pause),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .nota     (nota),
        .tocando  (tocando),
        .fim      (fim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= mem[mem_addr];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Expected song: words in order until a zero-duration marker or the end of the 64-word slot.
    function automatic void push_song(input logic [1:0] sel);
        ev_t e;
        logic [9:0] w;
        logic [5:0] i6;
        for (int i = 0; i < 64; i++) begin
            i6 = 6'(i);
            w = mem[{sel, i6}];
            if (w[3:0] == 4'd0) begin
                e.is_end = 1'b1; e.note = '0; e.ticks = 0;
                exp_q.push_back(e);
                return;
            end
            e.is_end = 1'b0; e.note = w[9:4]; e.ticks = int'(w[3:0]);
            exp_q.push_back(e);
        end
        e.is_end = 1'b1; e.note = '0; e.ticks = 0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_partial(input logic [5:0] note, input int ticks);
        ev_t e;
        e.is_end = 1'b0; e.note = note; e.ticks = ticks;
        exp_q.push_back(e);
    endfunction

    // Monitor: one note event per tocando high interval, one end event per fim pulse.
    logic       prev_toc = 1'b0;
    logic [5:0] cur_note = '0;
    int         cur_cnt  = 0;

    always @(negedge clk) begin
        ev_t e;
        if (tocando === 1'b1) begin
            if (!prev_toc) begin
                cur_note = nota;
                cur_cnt  = 0;
            end
            check("nota_hold", 32'(nota), 32'(cur_note));
            if (tick && !pause && !start) cur_cnt++;
        end
        if (tocando !== 1'b1 && prev_toc) begin
            if (exp_q.size() == 0) begin
                check("note_unexpected", 32'(cur_note), 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("note_kind", 32'(e.is_end), 32'd0);
                check("note_code", 32'(cur_note), 32'(e.note));
                check("note_ticks", 32'(cur_cnt), 32'(e.ticks));
            end
        end
        if (fim === 1'b1) begin
            check("fim_vs_tocando", 32'(tocando), 32'd0);
            if (exp_q.size() == 0) begin
                check("fim_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("fim_kind", 32'(e.is_end), 32'd1);
            end
        end
        prev_toc = (tocando === 1'b1);
    end

    task automatic pulse_start(input logic [1:0] sel, input bit tick_with);
        @(posedge clk); #1;
        select = sel; start = 1'b1; tick = tick_with; pause = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; tick = 1'b0;
        check("start_addr", 32'(mem_addr), 32'({sel, 6'd0}));
    endtask

    task automatic wait_toca();
        int c;
        for (c = 0; c < 100 && tocando !== 1'b1; c++) begin
            @(posedge clk); #1;
        end
        if (c >= 100) check("wait_toca_timeout", 32'(tocando), 32'd1);
    endtask

    task automatic run_song(input logic [1:0] sel, input int tick_pct, input int pause_pct,
                            input bit tick_on_start);
        bit done;
        push_song(sel);
        pulse_start(sel, tick_on_start);
        done = 1'b0;
        for (int c = 0; c < 8000 && !done; c++) begin
            if (fim === 1'b1) begin
                done = 1'b1;
            end else begin
                tick   = ($urandom_range(99) < tick_pct);
                pause  = ($urandom_range(99) < pause_pct);
                select = 2'($urandom);
                @(posedge clk); #1;
            end
        end
        tick = 1'b0; pause = 1'b0;
        if (!done) check("song_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        check("idle_nota", 32'(nota), 32'd0);
        check("idle_fim", 32'(fim), 32'd0);
    endtask

    initial begin
        logic [5:0] n6;
        bit idle_ok;
        select = 2'd0; start = 1'b0; tick = 1'b0; pause = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 10'h3FF;
        mem[8'h00] = {6'd21, 4'd5};  mem[8'h01] = {6'd3, 4'd2};  mem[8'h02] = {6'd0, 4'd0};
        mem[8'h40] = {6'd7, 4'd3};   mem[8'h41] = {6'd0, 4'd2};  mem[8'h42] = {6'd12, 4'd4};
        mem[8'h43] = {6'd1, 4'd0};
        mem[8'h80] = {6'd5, 4'd2};   mem[8'h81] = {6'd9, 4'd1};  mem[8'h82] = {6'd63, 4'd0};
        for (int i = 0; i < 64; i++) mem[8'hC0 + i] = {6'($urandom), 4'd1};

        #1 reset = 1'b0;
        #2;
        check("rst_nota", 32'(nota), 32'd0);
        check("rst_tocando", 32'(tocando), 32'd0);
        check("rst_fim", 32'(fim), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        idle_ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick = 1'b1; select = 2'($urandom);
            @(posedge clk); #1;
            if (tocando !== 1'b0 || fim !== 1'b0 || mem_addr !== 8'h00) idle_ok = 1'b0;
        end
        tick = 1'b0;
        check("idle_no_activity", 32'(idle_ok), 32'd1);

        run_song(2'd2, 40, 0, 1'b0);
        run_song(2'd1, 60, 50, 1'b0);

        pulse_start(2'd0, 1'b0);
        wait_toca();
        tick = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tick = 1'b0;
        push_partial(mem[8'h00][9:4], 2);
        run_song(2'd1, 50, 20, 1'b1);

        pulse_start(2'd1, 1'b0);
        wait_toca();
        tick = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tick = 1'b0;
        push_partial(mem[8'h40][9:4], 2);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_nota", 32'(nota), 32'd0);
        check("async_tocando", 32'(tocando), 32'd0);
        check("async_fim", 32'(fim), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick = ($urandom_range(1) == 1);
            @(posedge clk); #1;
            if (tocando !== 1'b0 || fim !== 1'b0 || mem_addr !== 8'h00) idle_ok = 1'b0;
        end
        tick = 1'b0;
        check("post_reset_idle", 32'(idle_ok), 32'd1);

        run_song(2'd3, 70, 10, 1'b0);
        check("no_wrap_addr", 32'(mem_addr), 32'hFF);
        run_song(2'd0, 50, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 3; s++) begin
                int len;
                len = $urandom_range(1, 6);
                for (int i = 0; i < 64; i++) begin
                    n6 = 6'($urandom);
                    mem[s*64 + i] = (i < len) ? {n6, 4'($urandom_range(1, 6))} : {n6, 4'd0};
                end
            end
            run_song(2'($urandom_range(2)), $urandom_range(30, 90), $urandom_range(0, 40),
                     1'($urandom));
        end

        repeat (5) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
